// File: rtl/modulo_receptor_varredura_display.sv
// Receiver for the multiplexed 4-digit 7-segment scan bus: deglitch, decode, frame assembly.
// Define DISPLAY_RX_DP_EN to add dp_mask (per-digit DP bits of the last valid frame).
module modulo_receptor_varredura_display #(
  parameter int unsigned STABLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Nseg,
  input  logic [3:0] Nanodo,
  output logic [6:0] garrafas,
  output logic [6:0] rolhas,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_lost,
  output logic [3:0] digitos_mask
`ifdef DISPLAY_RX_DP_EN
  ,
  output logic [3:0] dp_mask
`endif
);

  localparam logic [3:0] StableMax  = 4'(STABLE_CYCLES);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_CYCLES);

  // Active-high view of the bus; seg[6] is segment A.
  logic [6:0] seg;
  logic [3:0] en;
  logic       legal;

  assign seg   = ~Nseg[7:1];
  assign en    = ~Nanodo;
  assign legal = (en != 4'd0) && ((en & (en - 4'd1)) == 4'd0);

  // Segment pattern to BCD
  logic [3:0] bcd;
  logic       bcd_ok;

  always_comb begin
    bcd    = 4'd0;
    bcd_ok = 1'b1;
    case (seg)
      7'h7E:   bcd = 4'd0;
      7'h30:   bcd = 4'd1;
      7'h6D:   bcd = 4'd2;
      7'h79:   bcd = 4'd3;
      7'h33:   bcd = 4'd4;
      7'h5B:   bcd = 4'd5;
      7'h5F:   bcd = 4'd6;
      7'h70:   bcd = 4'd7;
      7'h7F:   bcd = 4'd8;
      7'h7B:   bcd = 4'd9;
      default: bcd_ok = 1'b0;
    endcase
  end

  // Stability tracking
  logic [6:0] prev_seg_q;
  logic [3:0] prev_en_q;
  logic [3:0] stab_q, stab_d;
  logic       same;
  logic       commit;

  assign same = (en == prev_en_q) && (seg == prev_seg_q);

  always_comb begin
    stab_d = 4'd0;
    if (legal) begin
      if (!same) begin
        stab_d = 4'd1;
      end else if (stab_q < StableMax) begin
        stab_d = stab_q + 4'd1;
      end else begin
        stab_d = stab_q;
      end
    end
  end

  // One commit per dwell; a new digit arriving while already saturated (STABLE_CYCLES=1) commits.
  assign commit = legal && (stab_d == StableMax) && (!same || (stab_q != StableMax));

  // Frame and link state
  logic [3:0] dig_q [4];
  logic [3:0] mask_q, mask_d;
  logic       err_q, err_d;
  logic [7:0] to_q, to_d;
  logic       frame_done;
  logic       timeout_hit;

  assign frame_done = (mask_q == 4'hF);

  always_comb begin
    to_d = to_q;
    if (commit) begin
      to_d = 8'd0;
    end else if (to_q < TimeoutMax) begin
      to_d = to_q + 8'd1;
    end
  end

  assign timeout_hit = (to_d == TimeoutMax) && (to_q != TimeoutMax);

  // A commit in the completion/timeout cycle belongs to the next frame.
  always_comb begin
    mask_d = mask_q;
    err_d  = err_q;
    if (frame_done || timeout_hit) begin
      mask_d = 4'd0;
      err_d  = 1'b0;
    end
    if (commit) begin
      mask_d = mask_d | en;
      if (!bcd_ok) begin
        err_d = 1'b1;
      end
    end
  end

  function automatic logic [6:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    logic [6:0] t;
    t = {3'd0, tens};
    return (t << 3) + (t << 1) + {3'd0, units};
  endfunction

`ifdef DISPLAY_RX_DP_EN
  logic [3:0] dp_dig_q;
`else
  logic unused_dp;
  assign unused_dp = Nseg[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_seg_q   <= 7'd0;
      prev_en_q    <= 4'd0;
      stab_q       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= 4'd0;
      end
      mask_q       <= 4'd0;
      err_q        <= 1'b0;
      to_q         <= 8'd0;
      garrafas     <= 7'd0;
      rolhas       <= 7'd0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      link_lost    <= 1'b0;
`ifdef DISPLAY_RX_DP_EN
      dp_dig_q     <= 4'd0;
      dp_mask      <= 4'd0;
`endif
    end else begin
      prev_seg_q  <= seg;
      prev_en_q   <= en;
      stab_q      <= stab_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      to_q        <= to_d;
      frame_valid <= frame_done && !err_q;
      frame_err   <= frame_done && err_q;

      for (int i = 0; i < 4; i++) begin
        if (commit && en[i]) begin
          if (bcd_ok) begin
            dig_q[i] <= bcd;
          end
`ifdef DISPLAY_RX_DP_EN
          dp_dig_q[i] <= ~Nseg[0];
`endif
        end
      end

      if (frame_done && !err_q) begin
        garrafas <= to_bin(dig_q[3], dig_q[2]);
        rolhas   <= to_bin(dig_q[1], dig_q[0]);
`ifdef DISPLAY_RX_DP_EN
        dp_mask  <= dp_dig_q;
`endif
      end

      if (commit) begin
        link_lost <= 1'b0;
      end else if (timeout_hit) begin
        link_lost <= 1'b1;
      end
    end
  end

  assign digitos_mask = mask_q;

endmodule

// File: tb/tb_modulo_receptor_varredura_display.sv
// Directed self-checking bench for modulo_receptor_varredura_display (default parameters).
module tb_modulo_receptor_varredura_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Nseg;
  logic [3:0] Nanodo;
  logic [6:0] garrafas;
  logic [6:0] rolhas;
  logic       frame_valid;
  logic       frame_err;
  logic       link_lost;
  logic [3:0] digitos_mask;
`ifdef DISPLAY_RX_DP_EN
  logic [3:0] dp_mask;
`endif

  modulo_receptor_varredura_display #(
    .STABLE_CYCLES (3),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Nseg        (Nseg),
    .Nanodo      (Nanodo),
    .garrafas    (garrafas),
    .rolhas      (rolhas),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .link_lost   (link_lost),
    .digitos_mask(digitos_mask)
`ifdef DISPLAY_RX_DP_EN
    ,
    .dp_mask     (dp_mask)
`endif
  );

  always #5 clk = ~clk;

  // Active-low segment codes (A..G in bits 7..1, DP in bit 0, DP off unless noted)
  localparam logic [7:0] S0   = 8'h03;
  localparam logic [7:0] S1   = 8'h9F;
  localparam logic [7:0] S2   = 8'h25;
  localparam logic [7:0] S3   = 8'h0D;
  localparam logic [7:0] S4   = 8'h99;
  localparam logic [7:0] S5   = 8'h49;
  localparam logic [7:0] S6   = 8'h41;
  localparam logic [7:0] S7   = 8'h1F;
  localparam logic [7:0] S8DP = 8'h00;
  localparam logic [7:0] S9   = 8'h09;
  localparam logic [7:0] SBAD = 8'h81;

  localparam logic [3:0] EBT = 4'b0111;
  localparam logic [3:0] EBU = 4'b1011;
  localparam logic [3:0] ECT = 4'b1101;
  localparam logic [3:0] ECU = 4'b1110;
  localparam logic [3:0] ENONE = 4'b1111;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic scan(input logic [3:0] an, input logic [7:0] sg, input int n);
    Nanodo = an;
    Nseg   = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [7:0] bt, input logic [7:0] bu,
                        input logic [7:0] ct, input logic [7:0] cu);
    scan(EBT, bt, 4);
    scan(EBU, bu, 4);
    scan(ECT, ct, 4);
    scan(ECU, cu, 4);
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    Nanodo = ENONE;
    Nseg   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (garrafas !== 7'd0 || rolhas !== 7'd0) begin
      errors++;
      $display("FAIL reset_values: got %0d/%0d required 0/0", garrafas, rolhas);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0 || link_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got fv=%b fe=%b ll=%b required 0/0/0",
               frame_valid, frame_err, link_lost);
    end
    checks++;
    if (digitos_mask !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mask: got %b required 0000", digitos_mask);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_frame;
    int fv0 = fv_cnt;
    scan(EBT, S1, 4);
    scan(EBU, S2, 4);
    scan(ECT, S4, 4);
    checks++;
    if (digitos_mask !== 4'b1110) begin
      errors++;
      $display("FAIL basic_partial_mask: got %b required 1110", digitos_mask);
    end
    scan(ECU, S7, 4);
    checks++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got fv=%b fe=%b required 1/0", frame_valid, frame_err);
    end
    checks++;
    if (garrafas !== 7'd12 || rolhas !== 7'd47) begin
      errors++;
      $display("FAIL basic_values: got %0d/%0d required 12/47", garrafas, rolhas);
    end
    checks++;
    if (digitos_mask !== 4'b0000) begin
      errors++;
      $display("FAIL basic_mask_clear: got %b required 0000", digitos_mask);
    end
    scan(ECU, S7, 1);
    checks++;
    if (frame_valid !== 1'b0 || fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL basic_single_pulse: got fv=%b count=%0d required 0/1",
               frame_valid, fv_cnt - fv0);
    end
  endtask

  task automatic test_error_frame;
    int fv0 = fv_cnt;
    int fe0 = fe_cnt;
    frame4(S1, S2, S4, SBAD);
    checks++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got fe=%b fv=%b required 1/0", frame_err, frame_valid);
    end
    checks++;
    if (garrafas !== 7'd12 || rolhas !== 7'd47) begin
      errors++;
      $display("FAIL err_hold: got %0d/%0d required 12/47", garrafas, rolhas);
    end
    scan(ECU, SBAD, 1);
    checks++;
    if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
      errors++;
      $display("FAIL err_counts: got fe=%0d fv=%0d required 1/0", fe_cnt - fe0, fv_cnt - fv0);
    end
    // Eight with DP lit is still a valid digit
    frame4(S1, S2, S4, S8DP);
    checks++;
    if (frame_valid !== 1'b1 || rolhas !== 7'd48 || garrafas !== 7'd12) begin
      errors++;
      $display("FAIL eight_frame: got fv=%b %0d/%0d required 1 12/48",
               frame_valid, garrafas, rolhas);
    end
    scan(ECU, S8DP, 1);
  endtask

  task automatic test_short_digit;
    int fv0 = fv_cnt;
    scan(EBT, S3, 2);
    scan(EBU, S6, 4);
    scan(ECT, S0, 4);
    scan(ECU, S5, 4);
    checks++;
    if (digitos_mask !== 4'b0111 || fv_cnt - fv0 !== 0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_no_frame: got mask=%b pulses=%0d required 0111/0",
               digitos_mask, fv_cnt - fv0);
    end
    scan(EBT, S3, 4);
    checks++;
    if (frame_valid !== 1'b1 || garrafas !== 7'd36 || rolhas !== 7'd5) begin
      errors++;
      $display("FAIL short_rescan: got fv=%b %0d/%0d required 1 36/5",
               frame_valid, garrafas, rolhas);
    end
    scan(EBT, S3, 1);
  endtask

  task automatic test_blank_multi;
    int fv0 = fv_cnt;
    scan(EBT, S1, 4);
    scan(4'b0011, S1, 10);
    checks++;
    if (digitos_mask !== 4'b1000) begin
      errors++;
      $display("FAIL multi_mask: got %b required 1000", digitos_mask);
    end
    checks++;
    if (dut.stab_q !== 4'd0) begin
      errors++;
      $display("FAIL multi_stab: got %0d required 0", dut.stab_q);
    end
    scan(EBU, S2, 4);
    scan(ECT, S4, 4);
    scan(ECU, S7, 4);
    checks++;
    if (frame_valid !== 1'b1 || garrafas !== 7'd12 || rolhas !== 7'd47) begin
      errors++;
      $display("FAIL multi_frame: got fv=%b %0d/%0d required 1 12/47",
               frame_valid, garrafas, rolhas);
    end
    scan(ECU, S7, 1);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL multi_pulses: got %0d required 1", fv_cnt - fv0);
    end
  endtask

  task automatic test_timeout;
    int fv0;
    // Commit one digit; the cycle after it the timeout counter reads 1.
    scan(EBT, S1, 4);
    scan(ENONE, S1, 62);
    checks++;
    if (link_lost !== 1'b0 || digitos_mask !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_early: got ll=%b mask=%b required 0/1000", link_lost, digitos_mask);
    end
    scan(ENONE, S1, 1);
    checks++;
    if (link_lost !== 1'b1 || digitos_mask !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_hit: got ll=%b mask=%b required 1/0000", link_lost, digitos_mask);
    end
    scan(ENONE, S1, 5);
    checks++;
    if (link_lost !== 1'b1 || garrafas !== 7'd12 || rolhas !== 7'd47) begin
      errors++;
      $display("FAIL timeout_hold: got ll=%b %0d/%0d required 1 12/47",
               link_lost, garrafas, rolhas);
    end
    fv0 = fv_cnt;
    scan(EBT, S3, 2);
    checks++;
    if (link_lost !== 1'b1) begin
      errors++;
      $display("FAIL resume_before_commit: got ll=%b required 1", link_lost);
    end
    scan(EBT, S3, 1);
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL resume_after_commit: got ll=%b required 0", link_lost);
    end
    scan(EBT, S3, 1);
    scan(EBU, S6, 4);
    scan(ECT, S0, 4);
    scan(ECU, S5, 4);
    checks++;
    if (frame_valid !== 1'b1 || garrafas !== 7'd36 || rolhas !== 7'd5) begin
      errors++;
      $display("FAIL resume_frame: got fv=%b %0d/%0d required 1 36/5",
               frame_valid, garrafas, rolhas);
    end
    scan(ECU, S5, 1);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL resume_pulses: got %0d required 1", fv_cnt - fv0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fv0 = fv_cnt;
    int fe0 = fe_cnt;
    scan(EBT, S9, 4);
    scan(EBU, S9, 4);
    checks++;
    if (digitos_mask !== 4'b1100) begin
      errors++;
      $display("FAIL mid_partial_mask: got %b required 1100", digitos_mask);
    end
    reset = 1'b1;
    scan(ENONE, 8'hFF, 1);
    checks++;
    if (garrafas !== 7'd0 || rolhas !== 7'd0 || digitos_mask !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_state: got %0d/%0d mask=%b required 0/0 0000",
               garrafas, rolhas, digitos_mask);
    end
    reset = 1'b0;
    frame4(S9, S9, S0, S0);
    checks++;
    if (frame_valid !== 1'b1 || garrafas !== 7'd99 || rolhas !== 7'd0) begin
      errors++;
      $display("FAIL mid_new_frame: got fv=%b %0d/%0d required 1 99/0",
               frame_valid, garrafas, rolhas);
    end
    scan(ECU, S0, 1);
    checks++;
    if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
      errors++;
      $display("FAIL mid_pulses: got fv=%0d fe=%0d required 1/0", fv_cnt - fv0, fe_cnt - fe0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_error_frame();
    test_short_digit();
    test_blank_multi();
    test_timeout();
    test_reset_mid_frame();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles required 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
